// File: rtl/phy_rx_sync_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : phy_rx_sync_ctrl_if
// Brief    : Two-lane RX sync controller bus; stats ports exist only with RX_STATS_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface phy_rx_sync_ctrl_if #(
    parameter int CNT_W = 16
);
    logic       enable;
    logic       resync_req;
    logic [7:0] data_in_0;
    logic [7:0] data_in_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       active_0;
    logic       active_1;
    logic       all_active;
`ifdef RX_STATS_EN
    logic [CNT_W-1:0] valid_cnt_0;
    logic [CNT_W-1:0] valid_cnt_1;
    logic [CNT_W-1:0] idle_cnt_0;
    logic [CNT_W-1:0] idle_cnt_1;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    modport master (
`ifdef RX_STATS_EN
        input  valid_cnt_0, valid_cnt_1, idle_cnt_0, idle_cnt_1,
`endif
        output enable, resync_req, data_in_0, data_in_1,
        input  data_out_0, data_out_1, valid_out_0, valid_out_1,
        input  active_0, active_1, all_active
    );

    modport slave (
`ifdef RX_STATS_EN
        output valid_cnt_0, valid_cnt_1, idle_cnt_0, idle_cnt_1,
`endif
        input  enable, resync_req, data_in_0, data_in_1,
        output data_out_0, data_out_1, valid_out_0, valid_out_1,
        output active_0, active_1, all_active
    );
endinterface

`default_nettype wire

// File: rtl/phy_rx_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module   : phy_rx_sync_ctrl
// Brief    : Per-lane comma hunt/lock FSMs for two RX lanes; optional RX_STATS_EN
//            macro adds saturating payload/idle counters.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phy_rx_sync_ctrl #(
    parameter logic [7:0] BC_CHAR = 8'hBC,
    parameter int         BC_LOCK = 4,
    parameter int         CNT_W   = 16
) (
    input  wire logic         clk_f,
    input  wire logic         reset_L,
    phy_rx_sync_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } lane_state_t;

    if (BC_LOCK < 1 || BC_LOCK > 15) begin : g_bad_bc_lock
        $error("BC_LOCK must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // enable low outranks resync_req, but both force the same hunt restart
    logic hunt_clr;
    assign hunt_clr = !bus.enable || bus.resync_req;

    for (genvar lane = 0; lane < 2; lane++) begin : g_lane
        logic [7:0]  din;
        logic        is_bc;
        logic        lock_hit;
        lane_state_t state;
        logic [3:0]  bc_cnt;
        logic [7:0]  dout;
        logic        valid;
        logic        active;

        assign din      = (lane == 0) ? bus.data_in_0 : bus.data_in_1;
        assign is_bc    = (din == BC_CHAR);
        assign lock_hit = (({1'b0, bc_cnt} + 5'd1) == 5'(BC_LOCK));

        always_ff @(posedge clk_f or negedge reset_L) begin
            if (!reset_L) begin
                state  <= HUNT;
                bc_cnt <= 4'd0;
                dout   <= 8'h00;
                valid  <= 1'b0;
                active <= 1'b0;
            end else if (hunt_clr) begin
                state  <= HUNT;
                bc_cnt <= 4'd0;
                dout   <= 8'h00;
                valid  <= 1'b0;
                active <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        dout  <= 8'h00;
                        valid <= 1'b0;
                        if (is_bc && lock_hit) begin
                            state  <= LOCK;
                            bc_cnt <= 4'd0;
                            active <= 1'b1;
                        end else if (is_bc) begin
                            bc_cnt <= bc_cnt + 4'd1;
                        end else begin
                            bc_cnt <= 4'd0;
                        end
                    end
                    LOCK: begin
                        dout  <= is_bc ? 8'h00 : din;
                        valid <= !is_bc;
                    end
                    default: begin
                        state  <= HUNT;
                        bc_cnt <= 4'd0;
                        dout   <= 8'h00;
                        valid  <= 1'b0;
                        active <= 1'b0;
                    end
                endcase
            end
        end

`ifdef RX_STATS_EN
        localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
        logic [CNT_W-1:0] valid_cnt;
        logic [CNT_W-1:0] idle_cnt;

        // counters sample the same locked cycle that produces the output byte
        always_ff @(posedge clk_f or negedge reset_L) begin
            if (!reset_L) begin
                valid_cnt <= '0;
                idle_cnt  <= '0;
            end else if (hunt_clr) begin
                valid_cnt <= '0;
                idle_cnt  <= '0;
            end else if (state == LOCK) begin
                if (!is_bc && (valid_cnt != '1)) begin
                    valid_cnt <= valid_cnt + CNT_ONE;
                end
                if (is_bc && (idle_cnt != '1)) begin
                    idle_cnt <= idle_cnt + CNT_ONE;
                end
            end
        end
`endif
    end

    logic all_active_r;

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            all_active_r <= 1'b0;
        end else begin
            all_active_r <= g_lane[0].active & g_lane[1].active;
        end
    end

    assign bus.data_out_0  = g_lane[0].dout;
    assign bus.data_out_1  = g_lane[1].dout;
    assign bus.valid_out_0 = g_lane[0].valid;
    assign bus.valid_out_1 = g_lane[1].valid;
    assign bus.active_0    = g_lane[0].active;
    assign bus.active_1    = g_lane[1].active;
    assign bus.all_active  = all_active_r;

`ifdef RX_STATS_EN
    assign bus.valid_cnt_0 = g_lane[0].valid_cnt;
    assign bus.valid_cnt_1 = g_lane[1].valid_cnt;
    assign bus.idle_cnt_0  = g_lane[0].idle_cnt;
    assign bus.idle_cnt_1  = g_lane[1].idle_cnt;
`endif

endmodule

`default_nettype wire
